// File: rtl/pc_sequencer_pkg.sv
// Shared encodings and defaults for the PC sequencer: FSM states,
// exception codes and the reset/vector addresses.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    PCS_RUN   = 2'd0,
    PCS_FLUSH = 2'd1,
    PCS_HALT  = 2'd2
  } pcs_state_t;

  localparam logic [4:0]  EXC_ADEL           = 5'd4;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Width-parameterised up-counter with synchronous clear that sticks at
// all-ones instead of wrapping; usable for any performance counter.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (en && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register of the single-cycle core: picks next PC from
// npc/exception vector/EPC/hold, and keeps EPC, Cause, EXL and stall stats.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      npc_in,
  input  logic             stall,
  input  logic             exc_req,
  input  logic [4:0]       exc_code,
  input  logic             eret,
  input  logic             halt_req,
  input  logic             resume,
  output logic [31:0]      pc,
  output logic             inst_valid,
  output logic [31:0]      epc,
  output logic [4:0]       cause,
  output logic             exl,
  output logic             halted,
  output logic             double_fault,
  output logic [CNT_W-1:0] stall_cycles
);

  pcs_state_t state;
  logic       take_eret;
  logic       take_exc;
  logic [4:0] exc_cd;
  logic       cnt_en;

  // Misalignment only matters when the plain npc advance would be taken.
  always_comb begin
    take_eret = eret && exl;
    take_exc  = exc_req ||
                (!halt_req && !stall && !take_eret && (npc_in[1:0] != 2'b00));
    exc_cd    = exc_req ? exc_code : EXC_ADEL;
    cnt_en    = (state == PCS_RUN) && stall && !take_exc && !halt_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PCS_RUN;
      pc           <= RESET_PC;
      epc          <= '0;
      cause        <= '0;
      exl          <= 1'b0;
      double_fault <= 1'b0;
    end else begin
      unique case (state)
        PCS_RUN: begin
          if (take_exc) begin
            if (!exl) begin
              epc   <= pc;
              cause <= exc_cd;
              exl   <= 1'b1;
              pc    <= EXC_VECTOR;
              state <= PCS_FLUSH;
            end else begin
              double_fault <= 1'b1;
              state        <= PCS_HALT;
            end
          end else if (halt_req) begin
            state <= PCS_HALT;
          end else if (stall) begin
            pc <= pc;
          end else if (take_eret) begin
            pc  <= epc;
            exl <= 1'b0;
          end else begin
            pc <= npc_in;
          end
        end
        PCS_FLUSH: state <= PCS_RUN;
        PCS_HALT: begin
          if (resume)
            state <= PCS_RUN;
        end
        default: state <= PCS_RUN;
      endcase
    end
  end

  assign inst_valid = (state == PCS_RUN);
  assign halted     = (state == PCS_HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (cnt_en),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic,
// checked against a behavioural model of the PC/exception rules.
module tb_pc_sequencer;

  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam logic [31:0] VEC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] npc_in = '0;
  logic        stall = 1'b0, exc_req = 1'b0, eret = 1'b0;
  logic        halt_req = 1'b0, resume = 1'b0;
  logic [4:0]  exc_code = '0;

  logic [31:0] pc, epc, pc_s, epc_s;
  logic [4:0]  cause, cause_s;
  logic        inst_valid, exl, halted, double_fault;
  logic        inst_valid_s, exl_s, halted_s, double_fault_s;
  logic [15:0] stall_cycles;
  logic [2:0]  stall_cycles_s;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .npc_in(npc_in), .stall(stall), .exc_req(exc_req),
    .exc_code(exc_code), .eret(eret), .halt_req(halt_req), .resume(resume),
    .pc(pc), .inst_valid(inst_valid), .epc(epc), .cause(cause), .exl(exl),
    .halted(halted), .double_fault(double_fault), .stall_cycles(stall_cycles)
  );

  pc_sequencer #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .npc_in(npc_in), .stall(stall), .exc_req(exc_req),
    .exc_code(exc_code), .eret(eret), .halt_req(halt_req), .resume(resume),
    .pc(pc_s), .inst_valid(inst_valid_s), .epc(epc_s), .cause(cause_s), .exl(exl_s),
    .halted(halted_s), .double_fault(double_fault_s), .stall_cycles(stall_cycles_s)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic        exl;
    logic        iv;
    logic        halted;
    logic        df;
    logic [15:0] sc;
    logic [2:0]  sc3;
  } exp_t;

  exp_t q[$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Behavioural model: mode is a small string-like tag, counter is unbounded.
  string       m_mode = "RUN";
  logic [31:0] m_pc = RPC, m_epc = '0;
  logic [4:0]  m_cause = '0;
  logic        m_exl = 1'b0, m_df = 1'b0;
  int unsigned m_stalls = 0;

  task automatic model_step(input logic r, input logic [31:0] n, input logic s,
                            input logic e, input logic [4:0] c, input logic er,
                            input logic h, input logic rs);
    logic fault;
    if (r) begin
      m_mode = "RUN"; m_pc = RPC; m_epc = '0; m_cause = '0;
      m_exl = 1'b0; m_df = 1'b0; m_stalls = 0;
    end else if (m_mode == "FLUSH") begin
      m_mode = "RUN";
    end else if (m_mode == "HALT") begin
      if (rs) m_mode = "RUN";
    end else begin
      fault = e;
      if (!e && !h && !s && !(er && m_exl) && (n % 4 != 0)) fault = 1'b1;
      if (fault) begin
        if (m_exl) begin
          m_df = 1'b1; m_mode = "HALT";
        end else begin
          m_epc = m_pc; m_cause = e ? c : 5'd4; m_exl = 1'b1;
          m_pc = VEC; m_mode = "FLUSH";
        end
      end else if (h) m_mode = "HALT";
      else if (s) m_stalls++;
      else if (er && m_exl) begin
        m_pc = m_epc; m_exl = 1'b0;
      end else m_pc = n;
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] n, input logic s,
                       input logic e, input logic [4:0] c, input logic er,
                       input logic h, input logic rs);
    exp_t x;
    @(posedge clk);
    #2;
    rst = r; npc_in = n; stall = s; exc_req = e; exc_code = c;
    eret = er; halt_req = h; resume = rs;
    model_step(r, n, s, e, c, er, h, rs);
    x.pc = m_pc; x.epc = m_epc; x.cause = m_cause; x.exl = m_exl;
    x.iv = (m_mode == "RUN"); x.halted = (m_mode == "HALT"); x.df = m_df;
    x.sc  = (m_stalls > 65535) ? 16'hFFFF : 16'(m_stalls);
    x.sc3 = (m_stalls > 7) ? 3'd7 : 3'(m_stalls);
    q.push_back(x);
  endtask

  task automatic step(input logic [31:0] n);
    drive(1'b0, n, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("pc",           pc,             x.pc);
      chk("epc",          epc,            x.epc);
      chk("cause",        32'(cause),     32'(x.cause));
      chk("exl",          32'(exl),       32'(x.exl));
      chk("inst_valid",   32'(inst_valid), 32'(x.iv));
      chk("halted",       32'(halted),    32'(x.halted));
      chk("double_fault", 32'(double_fault), 32'(x.df));
      chk("stall_cycles", 32'(stall_cycles), 32'(x.sc));
      chk("stall_sat3",   32'(stall_cycles_s), 32'(x.sc3));
      chk("pc_w3",        pc_s,           x.pc);
    end
  end

  initial begin
    logic [31:0] n;
    int unsigned sel;
    drive(1'b1, '0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(m_pc + 32'd4);
    // exception with code 12 at 0x3010, flush cycle ignores a second request
    drive(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0000_0001, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
    drive(1'b0, m_pc + 32'd4, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(m_pc + 32'd4);
    // misaligned jump target at 0x3020, then double fault
    step(32'h0000_3102);
    step(m_pc + 32'd4);
    drive(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
    drive(1'b0, m_pc + 32'd4, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, '0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    // ten stall cycles with changing (some misaligned) npc
    for (int i = 0; i < 10; i++)
      drive(1'b0, $urandom, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, m_pc + 32'd4, 1'b1, 1'b1, 5'd13, 1'b0, 1'b0, 1'b0);
    step(m_pc + 32'd4);
    drive(1'b0, m_pc + 32'd4, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, m_pc + 32'd4, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      drive(1'b0, $urandom, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, m_pc + 32'd8, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(m_pc + 32'd4);
    // reset during FLUSH and during HALT
    drive(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    drive(1'b1, m_pc + 32'd4, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    step(m_pc + 32'd4);
    drive(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    drive(1'b1, m_pc + 32'd4, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 11);
      n = $urandom;
      if (sel == 0) n[0] = 1'b1;
      else if (sel == 1) n[1:0] = 2'b00;
      else n = m_pc + 32'd4;
      drive($urandom_range(0, 79) == 0, n, $urandom_range(0, 3) == 0,
            $urandom_range(0, 11) == 0, 5'($urandom), $urandom_range(0, 5) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
